// File: rtl/stream_pkg.sv
// Stream fabric handshake constants and shared types for the cross-product expander.
package stream_pkg;

  localparam int MF_W   = 4;
  localparam int SF_W   = 2;

  localparam int MF_V   = 0;
  localparam int MF_L   = 1;
  localparam int MF_F   = 2;
  localparam int MF_A   = 3;

  localparam int SF_BSY = 0;
  localparam int SF_RSV = 1;

  typedef struct packed {
    logic a;
    logic f;
    logic l;
  } xflags_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } seq_state_e;

endpackage

// File: rtl/inner_seq_cnt.sv
// Inner-loop value counter: loads cnt_ini, steps by cnt_inc, flags the final value
// using one extra bit so a step past the top of the range never wraps back into it.
module inner_seq_cnt
  import stream_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] cnt_ini,
  input  logic [W-1:0] cnt_max,
  input  logic [W-1:0] cnt_inc,
  output logic [W-1:0] cnt,
  output logic         last,
  output logic         first
);

  logic [W:0] cnt_nxt;

  assign cnt_nxt = {1'b0, cnt} + {1'b0, cnt_inc};
  assign last    = (cnt_nxt > {1'b0, cnt_max}) || (cnt_inc == '0);
  assign first   = (cnt == cnt_ini);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= cnt_ini;
    end else if (step) begin
      cnt <= cnt_nxt[W-1:0];
    end
  end

endmodule

// File: rtl/cross_seq_pair.sv
// Streaming cross-product expander: each accepted x is emitted as (x, c) for every
// inner value c, one pair per cycle, with the next x loaded on the final pair's edge.
//
// state     | meaning
// ST_IDLE   | no element held; output register drains, upstream free
// ST_ACTIVE | x_reg held; one pair per unstalled cycle until the last inner value
module cross_seq_pair
  import stream_pkg::*;
#(
  parameter int W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    cnt_ini,
  input  logic [W-1:0]    cnt_max,
  input  logic [W-1:0]    cnt_inc,
  input  logic [W-1:0]    uc_d0,
  input  logic [MF_W-1:0] uc_mflags,
  output logic [SF_W-1:0] cu_sflags,
  output logic [W-1:0]    cd_d0,
  output logic [W-1:0]    cd_d1,
  output logic [MF_W-1:0] cd_mflags,
  input  logic [SF_W-1:0] dc_sflags
);

  seq_state_e   state;
  logic [W-1:0] x_reg;
  xflags_t      xf;
  logic [W-1:0] cnt;
  logic         last;
  logic         first;
  logic         active;
  logic         adv;
  logic         emit;
  logic         cu_bsy;
  logic         accept;
  logic         unused_rsv;

  assign unused_rsv = dc_sflags[SF_RSV];

  assign active = (state == ST_ACTIVE);
  assign adv    = ~cd_mflags[MF_V] | ~dc_sflags[SF_BSY];
  assign emit   = adv & active;
  // Upstream sees free on the edge the final pair leaves, so the next x loads without a bubble.
  assign cu_bsy = active & ~(adv & last);
  assign accept = uc_mflags[MF_V] & ~cu_bsy;

  always_comb begin
    cu_sflags         = '0;
    cu_sflags[SF_BSY] = cu_bsy;
  end

  inner_seq_cnt #(.W(W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .step    (emit),
    .cnt_ini (cnt_ini),
    .cnt_max (cnt_max),
    .cnt_inc (cnt_inc),
    .cnt     (cnt),
    .last    (last),
    .first   (first)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      x_reg     <= '0;
      xf        <= '0;
      cd_d0     <= '0;
      cd_d1     <= '0;
      cd_mflags <= '0;
    end else begin
      if (adv) begin
        if (active) begin
          cd_d0           <= x_reg;
          cd_d1           <= cnt;
          cd_mflags[MF_V] <= 1'b1;
          cd_mflags[MF_F] <= xf.f & first;
          cd_mflags[MF_L] <= xf.l & last;
          cd_mflags[MF_A] <= xf.a;
        end else begin
          cd_mflags[MF_V] <= 1'b0;
        end
      end
      if (emit && last) begin
        state <= ST_IDLE;
      end
      if (accept) begin
        x_reg <= uc_d0;
        xf    <= '{a: uc_mflags[MF_A], f: uc_mflags[MF_F], l: uc_mflags[MF_L]};
        state <= ST_ACTIVE;
      end
    end
  end

endmodule

// File: tb/tb_cross_seq_pair.sv
// Self-checking bench for cross_seq_pair: pair scoreboard plus a pending-pair count model.
module tb_cross_seq_pair;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cnt_ini, cnt_max, cnt_inc;
  logic [15:0] uc_d0;
  logic [3:0]  uc_mflags;
  logic [1:0]  cu_sflags;
  logic [15:0] cd_d0, cd_d1;
  logic [3:0]  cd_mflags;
  logic [1:0]  dc_sflags;

  cross_seq_pair #(.W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_ini   (cnt_ini),
    .cnt_max   (cnt_max),
    .cnt_inc   (cnt_inc),
    .uc_d0     (uc_d0),
    .uc_mflags (uc_mflags),
    .cu_sflags (cu_sflags),
    .cd_d0     (cd_d0),
    .cd_d1     (cd_d1),
    .cd_mflags (cd_mflags),
    .dc_sflags (dc_sflags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [3:0]  fl;
  } pair_t;

  typedef struct {
    logic [15:0] ini;
    logic [15:0] max;
    logic [15:0] inc;
    logic [15:0] x;
    int          n_exp;
    logic [15:0] first_c;
    logic [15:0] last_c;
  } vec_t;

  pair_t       exp_q[$];
  int          pending;
  bit          out_v;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_xfer;
  int          n_f, n_l;
  logic [15:0] first_c, last_c;
  int          bsy_mode;
  int          cyc = 0;
  logic [15:0] feed_x[$];
  logic [3:0]  feed_fl[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // All pairs produced for one element, in emission order.
  function automatic int gen_pairs(input logic [15:0] x, input logic [3:0] fl);
    longint c = cnt_ini;
    int     n = 0;
    bit     is_last;
    pair_t  p;
    do begin
      is_last = (cnt_inc == 0) || (c + cnt_inc > cnt_max);
      p.d0 = x;
      p.d1 = c[15:0];
      p.fl = {fl[3], fl[2] & (n == 0), fl[1] & is_last, 1'b1};
      exp_q.push_back(p);
      n++;
      c += cnt_inc;
    end while (!is_last);
    return n;
  endfunction

  function automatic bit get_bsy();
    case (bsy_mode)
      1:       return (cyc % 12) >= 10;
      2:       return $urandom_range(0, 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic cycle(input bit v, input logic [15:0] x, input logic [3:0] fl, output bit acc);
    bit          bsy, adv_m, exp_bsy, hold;
    logic [15:0] h0, h1;
    logic [3:0]  hf;
    pair_t       p;
    bsy       = get_bsy();
    uc_d0     = v ? x : 16'h0;
    uc_mflags = v ? {fl[3:1], 1'b1} : 4'h0;
    dc_sflags = {1'b0, bsy};
    @(negedge clk);
    adv_m   = !out_v || !bsy;
    exp_bsy = (pending > 0) && !(adv_m && pending == 1);
    check("cu_sflags", cu_sflags, {1'b0, exp_bsy});
    check("cd_valid", cd_mflags[0], out_v);
    if (out_v && !bsy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pair", 1, 0);
      end else begin
        p = exp_q.pop_front();
        check("cd_d0", cd_d0, p.d0);
        check("cd_d1", cd_d1, p.d1);
        check("cd_mflags", cd_mflags, p.fl);
      end
      if (n_xfer == 0) first_c = cd_d1;
      last_c = cd_d1;
      n_f += cd_mflags[2];
      n_l += cd_mflags[1];
      n_xfer++;
    end
    hold = out_v && bsy;
    h0 = cd_d0; h1 = cd_d1; hf = cd_mflags;
    acc = v && !exp_bsy;
    if (adv_m) begin
      out_v = pending > 0;
      if (pending > 0) pending--;
    end
    if (acc) pending = gen_pairs(x, fl);
    @(posedge clk);
    cyc++;
    #1;
    if (hold) begin
      check("hold_d0", cd_d0, h0);
      check("hold_d1", cd_d1, h1);
      check("hold_mflags", cd_mflags, hf);
    end
  endtask

  task automatic drain();
    bit acc;
    int guard = 0;
    while ((pending > 0 || out_v) && guard < 3000) begin
      cycle(0, 16'h0, 4'h0, acc);
      guard++;
    end
    if (guard >= 3000) check("drain_timeout", guard, 0);
  endtask

  task automatic run_feed();
    bit acc;
    int guard;
    n_xfer = 0; n_f = 0; n_l = 0;
    foreach (feed_x[i]) begin
      acc = 0;
      guard = 0;
      while (!acc && guard < 3000) begin
        cycle(1, feed_x[i], feed_fl[i], acc);
        guard++;
      end
      if (!acc) check("accept_timeout", guard, 0);
    end
    drain();
    feed_x.delete();
    feed_fl.delete();
  endtask

  task automatic set_cfg(input logic [15:0] ini, input logic [15:0] max, input logic [15:0] inc);
    cnt_ini = ini; cnt_max = max; cnt_inc = inc;
  endtask

  vec_t vecs[8];

  initial begin
    bit acc;
    bit found;
    int guard;

    vecs[0] = '{16'd1,    16'd9,    16'd1,    16'h0003, 9, 16'd1,    16'd9};
    vecs[1] = '{16'd3,    16'd2,    16'd1,    16'h0007, 1, 16'd3,    16'd3};
    vecs[2] = '{16'd4,    16'd9,    16'd0,    16'h0011, 1, 16'd4,    16'd4};
    vecs[3] = '{16'hFFFE, 16'hFFFF, 16'd1,    16'h0022, 2, 16'hFFFE, 16'hFFFF};
    vecs[4] = '{16'd1,    16'd9,    16'd4,    16'h0033, 3, 16'd1,    16'd9};
    vecs[5] = '{16'd0,    16'd10,   16'd3,    16'h0044, 4, 16'd0,    16'd9};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0055, 1, 16'hFFFF, 16'hFFFF};
    vecs[7] = '{16'd0,    16'hFFFF, 16'h8000, 16'h0066, 2, 16'd0,    16'h8000};

    rst = 1'b1;
    uc_d0 = '0; uc_mflags = '0; dc_sflags = '0;
    set_cfg(16'd1, 16'd9, 16'd1);
    pending = 0; out_v = 0; bsy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_cd_mflags", cd_mflags, 0);
    check("rst_cu_sflags", cu_sflags, 0);
    check("rst_cd_d0", cd_d0, 0);
    check("rst_cd_d1", cd_d1, 0);

    // x = 1..5, F on first, L on last, unstalled and then with a 10/2 busy pattern.
    for (int m = 0; m < 2; m++) begin
      bsy_mode = m;
      for (int i = 1; i <= 5; i++) begin
        feed_x.push_back(16'(i));
        feed_fl.push_back({1'b0, i == 1, i == 5, 1'b1});
      end
      run_feed();
      check("seq_pair_count", n_xfer, 45);
      check("seq_f_count", n_f, 1);
      check("seq_l_count", n_l, 1);
    end

    bsy_mode = 0;
    foreach (vecs[i]) begin
      set_cfg(vecs[i].ini, vecs[i].max, vecs[i].inc);
      feed_x.push_back(vecs[i].x);
      feed_fl.push_back(4'b0111);
      run_feed();
      check("vec_count", n_xfer, vecs[i].n_exp);
      check("vec_first_c", first_c, vecs[i].first_c);
      check("vec_last_c", last_c, vecs[i].last_c);
    end

    // Back-to-back elements with a stride; the model flags any idle gap via cd_valid.
    set_cfg(16'd1, 16'd9, 16'd4);
    feed_x.push_back(16'd1); feed_fl.push_back(4'b0101);
    feed_x.push_back(16'd2); feed_fl.push_back(4'b1011);
    run_feed();
    check("b2b_count", n_xfer, 6);

    // Reset while pair (3,5) sits on the output.
    set_cfg(16'd1, 16'd9, 16'd1);
    n_xfer = 0;
    acc = 0; guard = 0;
    while (!acc && guard < 100) begin
      cycle(1, 16'd3, 4'b0111, acc);
      guard++;
    end
    found = 0; guard = 0;
    while (!found && guard < 100) begin
      cycle(0, 16'h0, 4'h0, acc);
      found = cd_mflags[0] && cd_d0 == 16'd3 && cd_d1 == 16'd5;
      guard++;
    end
    check("rst_target_seen", found, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_cd_mflags", cd_mflags, 0);
    check("midrst_cu_sflags", cu_sflags, 0);
    check("midrst_cd_d1", cd_d1, 0);
    exp_q.delete(); pending = 0; out_v = 0;
    feed_x.push_back(16'd2); feed_fl.push_back(4'b0111);
    run_feed();
    check("post_rst_count", n_xfer, 9);

    // Random configurations, upstream valid and downstream busy.
    bsy_mode = 2;
    for (int k = 0; k < 6; k++) begin
      set_cfg(16'($urandom_range(0, 20)), 16'($urandom_range(0, 20)), 16'($urandom_range(0, 4)));
      for (int t = 0; t < 200; t++) begin
        cycle($urandom_range(0, 1) == 1, 16'($urandom), 4'($urandom), acc);
      end
      drain();
    end
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
